// File: rtl/pattern_bit_serializer_if.sv
// Load-side handshake bundle for pattern_bit_serializer.
// master = upstream word source, slave = the serializer.
interface pattern_bit_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;

   modport master (output load_data, output load_valid, input load_ready);
   modport slave  (input load_data, input load_valid, output load_ready);
endinterface

// File: rtl/pattern_bit_serializer.sv
// Parallel-to-serial front end for the serial pattern detectors.
// Accepts a WIDTH-bit word over valid/ready and shifts it out one bit per
// clock on bit_o, streaming back-to-back words with no gap cycles.
// Optional feature macro: PATTERN_SER_REPEAT_EN adds repeat_i, which restarts
// the last captured word from a held copy when no new word arrives.
module pattern_bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst,
   pattern_bit_serializer_if.slave load,
`ifdef PATTERN_SER_REPEAT_EN
   input  logic                    repeat_i,
`endif
   output logic                    bit_o,
   output logic                    bit_valid,
   output logic                    busy,
   output logic                    done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             bit_q, bit_d;
   logic             active_q, active_d;
   logic             last;
   logic             accept;
`ifdef PATTERN_SER_REPEAT_EN
   logic [WIDTH-1:0] hold_q, hold_d;
`endif

   // The register's head bit is always the bit presented on bit_o.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Advance the register so the next bit moves into the head position.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // Handshake and done are decoded from state/counter only, never from load_valid.
   assign last            = (state_q == SHIFT) && (cnt_q == LAST);
   assign load.load_ready = (state_q == IDLE) || last;
   assign done            = last;
   assign accept          = load.load_valid && load.load_ready;

   assign bit_o     = bit_q;
   assign bit_valid = active_q;
   assign busy      = active_q;

   // Next-state: new word wins, then repeat (if built), then shift or go idle.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
`ifdef PATTERN_SER_REPEAT_EN
      hold_d  = hold_q;
`endif
      if (accept) begin
         state_d = SHIFT;
         sreg_d  = load.load_data;
         cnt_d   = '0;
`ifdef PATTERN_SER_REPEAT_EN
         hold_d  = load.load_data;
`endif
      end else if (state_q == SHIFT) begin
         if (last) begin
`ifdef PATTERN_SER_REPEAT_EN
            if (repeat_i) begin
               sreg_d = hold_q;
               cnt_d  = '0;
            end else
`endif
            begin
               state_d = IDLE;
               sreg_d  = shift_word(sreg_q);
               cnt_d   = '0;
            end
         end else begin
            sreg_d = shift_word(sreg_q);
            cnt_d  = cnt_q + CW'(1);
         end
      end
      // Outputs are precomputed from the next state so they leave a flop.
      active_d = (state_d == SHIFT);
      bit_d    = (state_d == SHIFT) ? head_bit(sreg_d) : IDLE_BIT;
   end

   // State, datapath and registered outputs; reset discards any partial word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sreg_q   <= '0;
         cnt_q    <= '0;
         bit_q    <= IDLE_BIT;
         active_q <= 1'b0;
`ifdef PATTERN_SER_REPEAT_EN
         hold_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         sreg_q   <= sreg_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         active_q <= active_d;
`ifdef PATTERN_SER_REPEAT_EN
         hold_q   <= hold_d;
`endif
      end
   end

endmodule
